// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the prefetching fetch stage:
//   - PC source select encodings driven by Decode (id_if_selpctype)
//   - the NOP word pushed into IF/ID when no instruction is available
//   - instruction word width
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        PCSEL_IMM = 2'b00,
        PCSEL_REG = 2'b01,
        PCSEL_IDX = 2'b10,
        PCSEL_EXC = 2'b11
    } pcsel_e;

endpackage

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small circular prefetch queue used between instruction memory and Decode.
// Head is read straight out of the storage registers so Decode sees the
// oldest entry without an extra cycle.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   flush             drop all entries (pointers and count back to zero)
//   push, push_data   write one entry at the tail
//   pop               consume the head entry (ignored when empty)
//   head              oldest entry
//   count             number of valid entries (0..DEPTH)
//   full, empty       occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A write into a full queue is only safe when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign head    = store[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own;
    // count carries one extra bit to tell full from empty
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only ever read after it was written
    always_ff @(posedge clock) begin
        if (do_push && !flush) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Fetch stage with PC generation and a prefetch queue in front of Decode.
// Keeps fetching while Decode stalls, absorbs the one-cycle memory latency,
// and flushes everything (queue and in-flight read) on a redirect.
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   id_stall                  Decode cannot accept; IF/ID outputs hold
//   id_if_selpcsource         redirect request (taken only when not stalled)
//   id_if_selpctype           target select: imm / rega / pcindex / EXC_VECTOR
//   id_if_rega, id_if_pcimd2ext, id_if_pcindex   candidate targets
//   imem_req, imem_addr       combinational read request to instruction memory
//   imem_data                 read data, one cycle after imem_req
//   if_id_instruc, if_id_nextpc, if_id_valid     IF/ID pipeline registers
// Configuration macro FETCH_PERF_EN adds perf_fetch_cnt (accepted responses)
// and perf_redirect_cnt (taken redirects).
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                IMEM_AW    = 7,
    parameter int                QDEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'('h40)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               id_stall,
    input  logic               id_if_selpcsource,
    input  logic [1:0]         id_if_selpctype,
    input  logic [ADDR_W-1:0]  id_if_rega,
    input  logic [ADDR_W-1:0]  id_if_pcimd2ext,
    input  logic [ADDR_W-1:0]  id_if_pcindex,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] if_id_instruc,
    output logic [ADDR_W-1:0]  if_id_nextpc,
    output logic               if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_redirect_cnt
`endif
);

    localparam int CNT_W   = $clog2(QDEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               inflight;
    logic               redirect_take;
    logic [ADDR_W-1:0]  redirect_target;
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    // A stalled Decode keeps its redirect pending; we only act once it can move
    assign redirect_take = id_if_selpcsource && !id_stall;

    // Reserve a slot for every outstanding read so a response can never overflow
    assign imem_req  = !fifo_full && ((fifo_count + CNT_W'(inflight)) < CNT_W'(QDEPTH))
                       && !redirect_take;
    assign imem_addr = pc[IMEM_AW+1:2];

    assign fifo_push = inflight && !redirect_take;
    assign fifo_pop  = !id_stall && !redirect_take;

    // Redirect target select
    always_comb begin
        redirect_target = id_if_pcimd2ext;
        case (pcsel_e'(id_if_selpctype))
            PCSEL_IMM: redirect_target = id_if_pcimd2ext;
            PCSEL_REG: redirect_target = id_if_rega;
            PCSEL_IDX: redirect_target = id_if_pcindex;
            PCSEL_EXC: redirect_target = EXC_VECTOR;
            default:   redirect_target = id_if_pcimd2ext;
        endcase
    end

    // Queue entries carry the already-incremented PC alongside the word
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_take),
        .push      (fifo_push),
        .push_data ({req_pc + ADDR_W'(4), imem_data}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // PC and in-flight tracking: a redirect kills the outstanding read and
    // issues nothing itself, so the first fetch of the target leaves next cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else if (redirect_take) begin
            pc       <= redirect_target;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc     <= pc + ADDR_W'(4);
                req_pc <= pc;
            end
        end
    end

    // IF/ID registers: hold on stall, bubble with NOP when the queue is dry;
    // nextpc keeps its last value across bubbles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_id_instruc <= NOP_INSTR;
            if_id_nextpc  <= '0;
            if_id_valid   <= 1'b0;
        end else if (redirect_take) begin
            if_id_instruc <= NOP_INSTR;
            if_id_valid   <= 1'b0;
        end else if (!id_stall) begin
            if (!fifo_empty) begin
                if_id_nextpc  <= fifo_head[ENTRY_W-1:INSTR_W];
                if_id_instruc <= fifo_head[INSTR_W-1:0];
                if_id_valid   <= 1'b1;
            end else begin
                if_id_instruc <= NOP_INSTR;
                if_id_valid   <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters; wrap naturally at 2^32
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (fifo_push)     perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
            if (redirect_take) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule
